rob_status_mw: RTL and testbench
================================

# rob_status_mw

Multi-way reorder-buffer status tracker for the out-of-order core: allocates up to DEC_WIDTH entries per cycle at decode, accepts completion from WB_PORTS writeback ports, and retires up to COM_WIDTH oldest completed entries per cycle in program order. It sits between decode/rename and the commit stage and generalises the single-issue ROB status block. It also raises the pipeline flush on the first retiring entry with an exception, branch mispredict or jump mispredict.

## Interface
Parameters:
- ADDR, `AddrWidth: PC width
- ROB_DEPTH, `RobDepth: entries; power of 2, ≥ 2*DEC_WIDTH
- DEC_WIDTH, 2: allocation slots per cycle
- WB_PORTS, 2: writeback ports
- COM_WIDTH, 2: retire lanes per cycle
- ROB, $clog2(ROB_DEPTH): entry-id width (derived)

Ports (vectors are lane-packed; lane 0 = LSBs = oldest):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dec_e_  in  DEC_WIDTH  per-slot allocate, active-low; enabled slots contiguous from slot 0
- dec_pc  in  DEC_WIDTH*ADDR  per-slot PC
- dec_rd  in  DEC_WIDTH*$bits(RegFile_t)  per-slot destination
- dec_invalid  in  DEC_WIDTH  slot is an illegal instruction
- dec_rob_id  out  ROB  id of slot 0 (slot k gets dec_rob_id+k mod ROB_DEPTH)
- ren_id  in  2*DEC_WIDTH*ROB  rename source lookups
- ren_ready  out  2*DEC_WIDTH  looked-up entry completed
- wb_e_  in  WB_PORTS  writeback valid, active-low
- wb_rob_id  in  WB_PORTS*ROB  completing entry
- wb_exp_, wb_pred_miss_, wb_jump_miss_  in  WB_PORTS each  active-low status flags
- wb_exp_code  in  WB_PORTS*$bits(ExpCode_t)  exception code
- com_e_  out  COM_WIDTH  lane retires, active-low
- com_pc, com_rd, com_exp_code, com_rob_id  out  per-lane  fields of retiring entry
- com_exp_  out  COM_WIDTH  lane has exception, active-low
- flush_  out  1  flush pipeline, active-low
- rob_busy  out  1  fewer than DEC_WIDTH free entries

## Operation
- State: head, tail (ROB bits, wrap mod ROB_DEPTH), count (ROB+1 bits), per-entry valid, done, info {pc, rd}, status {br_miss_, jump_miss_, exp_, exp_code}.
- Allocate: when rob_busy low, each enabled slot k writes entry tail+k: valid=1, info stored, done=dec_invalid[k], status cleared, except invalid slots store exp_ asserted with illegal-instruction code. tail advances by number of enabled slots. Allocation while rob_busy high is dropped (tail, count unchanged).
- Writeback: each enabled port sets done and stores status for its entry if valid; writes to invalid entries ignored. Two ports to the same entry in one cycle: higher port index wins.
- Retire: lane i considers entry head+i; lane i retires iff lanes 0..i-1 retire, entry valid and done, and no earlier retiring lane flagged. A lane flagged (exp_, br_miss_ or jump_miss_ asserted) retires and stops further lanes that cycle. head advances by lanes retired.
- flush_ asserted combinationally when any retiring lane is flagged. Next cycle: all valid/done cleared, head=tail=count=0; allocations and writebacks in the flush cycle discarded.
- ren_ready[j] = done of entry ren_id[j], OR-ed with same-cycle writeback match (bypass).
- count_next = count + allocated − retired; rob_busy = (ROB_DEPTH − count) < DEC_WIDTH.
- Non-retiring lanes: com_e_ high, other com_* fields driven to 0 (com_exp_ high).

## Timing
- Reset: head=tail=count=0, all valid/done 0; outputs: dec_rob_id=0, com_e_ all 1, flush_=1, rob_busy=0, ren_ready 0. Reset overrides flush and all inputs.
- Allocate → earliest retire: next cycle if done at allocation (invalid), else cycle after writeback.
- Writeback → retire: 1 cycle (done registered); ren_ready sees writeback same cycle.
- Simultaneous allocate and retire in one cycle: both applied; allocate checked against pre-retire count.
- Full (count=ROB_DEPTH): rob_busy=1, retire unaffected. Pointer wrap: tail/head ROB_DEPTH−1 → 0.

## Test plan
- Reset then allocate 2 slots (pc 0x100, 0x104) → dec_rob_id=0; next dec_rob_id=2; no retire before writeback.
- Writeback ids 1 then 0 (separate cycles) → no retire after id 1; both retire together one cycle after id 0, com_rob_id={1,0}.
- Fill to ROB_DEPTH−1 → rob_busy=1, next allocation dropped; retire 1 → rob_busy=0 next cycle; allocation wraps tail to 0.
- Entries 0,1 done, entry 0 with wb_pred_miss_=0 → only lane 0 retires, flush_=0 that cycle; next cycle count=0, head=tail=0.
- dec_invalid on slot 0 → entry retires next cycle with com_exp_=0, flush_=0.
- Both WB ports target id 3 same cycle, port 1 exp_ asserted → id 3 retires with exception and ren_ready for id 3 high in the writeback cycle.

Source files
------------

// File: rtl/rob_status_mw.sv
// -----------------------------------------------------------------------------
// rob_status_mw -- multi-way reorder-buffer status tracker.
//
// Allocates up to DEC_WIDTH entries per cycle at decode, marks entries complete
// from WB_PORTS writeback ports, and retires up to COM_WIDTH of the oldest
// completed entries per cycle in program order. The first retiring entry that
// carries an exception, branch mispredict or jump mispredict raises flush_.
// The ROB is then emptied on the next clock edge.
//
// Ports (lane-packed vectors, lane 0 in the LSBs is the oldest):
//   clk, reset                 clock, synchronous active-high reset
//   dec_e_, dec_pc, dec_rd,    per-slot allocate (active-low), PC, destination,
//   dec_invalid                illegal-instruction marker
//   dec_rob_id                 id given to slot 0 (slot k gets +k)
//   ren_id / ren_ready         rename lookups, completion status (with bypass)
//   wb_e_, wb_rob_id, wb_exp_, writeback valid, entry id, active-low status
//   wb_pred_miss_,             flags and exception code
//   wb_jump_miss_, wb_exp_code
//   com_e_, com_pc, com_rd,    per-lane retire (active-low) and fields of the
//   com_exp_code, com_rob_id,  retiring entry; com_exp_ is active-low
//   com_exp_
//   flush_                     pipeline flush, active-low
//   rob_busy                   fewer than DEC_WIDTH free entries
// -----------------------------------------------------------------------------
module rob_status_mw #(
    parameter int ADDR         = 32,
    parameter int ROB_DEPTH    = 8,
    parameter int DEC_WIDTH    = 2,
    parameter int WB_PORTS     = 2,
    parameter int COM_WIDTH    = 2,
    parameter int RD_W         = 5,
    parameter int EXP_W        = 4,
    parameter int ILLEGAL_CODE = 2,
    parameter int ROB          = $clog2(ROB_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DEC_WIDTH-1:0]          dec_e_,
    input  logic [DEC_WIDTH*ADDR-1:0]     dec_pc,
    input  logic [DEC_WIDTH*RD_W-1:0]     dec_rd,
    input  logic [DEC_WIDTH-1:0]          dec_invalid,
    output logic [ROB-1:0]                dec_rob_id,
    input  logic [2*DEC_WIDTH*ROB-1:0]    ren_id,
    output logic [2*DEC_WIDTH-1:0]        ren_ready,
    input  logic [WB_PORTS-1:0]           wb_e_,
    input  logic [WB_PORTS*ROB-1:0]       wb_rob_id,
    input  logic [WB_PORTS-1:0]           wb_exp_,
    input  logic [WB_PORTS-1:0]           wb_pred_miss_,
    input  logic [WB_PORTS-1:0]           wb_jump_miss_,
    input  logic [WB_PORTS*EXP_W-1:0]     wb_exp_code,
    output logic [COM_WIDTH-1:0]          com_e_,
    output logic [COM_WIDTH*ADDR-1:0]     com_pc,
    output logic [COM_WIDTH*RD_W-1:0]     com_rd,
    output logic [COM_WIDTH*EXP_W-1:0]    com_exp_code,
    output logic [COM_WIDTH*ROB-1:0]      com_rob_id,
    output logic [COM_WIDTH-1:0]          com_exp_,
    output logic                          flush_,
    output logic                          rob_busy
);

    localparam int SLOT_W = (DEC_WIDTH > 1) ? $clog2(DEC_WIDTH) : 1;
    localparam int PORT_W = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
    localparam logic [ROB:0]     DEPTH_C = (ROB+1)'(ROB_DEPTH);
    localparam logic [ROB:0]     DECW_C  = (ROB+1)'(DEC_WIDTH);
    localparam logic [ROB:0]     ONE_C   = (ROB+1)'(1);
    localparam logic [EXP_W-1:0] ILL_C   = EXP_W'(ILLEGAL_CODE);

    // Pointers, occupancy and per-entry control bits
    logic [ROB-1:0]       head_q, head_d, tail_q, tail_d;
    logic [ROB:0]         count_q, count_d;
    logic [ROB_DEPTH-1:0] valid_q, valid_d, done_q, done_d;

    // Entry payload; status flags are stored active-low like the ports
    logic [ADDR-1:0]      pc_q       [ROB_DEPTH];
    logic [RD_W-1:0]      rd_q       [ROB_DEPTH];
    logic [EXP_W-1:0]     exp_code_q [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] br_miss_q, jump_miss_q, exp_q;

    // Per-entry write strobes decoded from the slot/port/lane views
    logic [ROB_DEPTH-1:0] alloc_we, wb_we, ret_clr;
    logic [SLOT_W-1:0]    alloc_slot [ROB_DEPTH];
    logic [PORT_W-1:0]    wb_port    [ROB_DEPTH];
    logic [ROB:0]         nalloc, nret;
    logic                 flush, busy;

    // Busy is judged on the pre-retire occupancy, so a retire in the same
    // cycle does not open room for that cycle's allocation.
    assign busy       = !reset && ((DEPTH_C - count_q) < DECW_C);
    assign rob_busy   = busy;
    assign dec_rob_id = reset ? '0 : tail_q;
    assign flush_     = !flush;

    // Allocation: enabled slot k lands on tail+k
    always_comb begin
        logic [ROB-1:0] a_idx;
        a_idx    = '0;
        nalloc   = '0;
        alloc_we = '0;
        for (int e = 0; e < ROB_DEPTH; e++) alloc_slot[e] = '0;
        for (int k = 0; k < DEC_WIDTH; k++) begin
            if (!reset && !busy && !dec_e_[k]) begin
                a_idx             = tail_q + ROB'(k);
                alloc_we[a_idx]   = 1'b1;
                alloc_slot[a_idx] = SLOT_W'(k);
                nalloc            = nalloc + ONE_C;
            end
        end
    end

    // Writeback: later ports overwrite earlier ones, so the highest index wins
    always_comb begin
        logic [ROB-1:0] w_idx;
        w_idx = '0;
        wb_we = '0;
        for (int e = 0; e < ROB_DEPTH; e++) wb_port[e] = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            w_idx = wb_rob_id[p*ROB +: ROB];
            if (!wb_e_[p] && valid_q[w_idx]) begin
                wb_we[w_idx]   = 1'b1;
                wb_port[w_idx] = PORT_W'(p);
            end
        end
    end

    // Retire: in-order chain from head; a flagged entry retires but ends the chain
    always_comb begin
        logic [ROB-1:0] r_idx;
        logic           stop;
        r_idx        = '0;
        stop         = 1'b0;
        ret_clr      = '0;
        nret         = '0;
        flush        = 1'b0;
        com_e_       = '1;
        com_exp_     = '1;
        com_pc       = '0;
        com_rd       = '0;
        com_exp_code = '0;
        com_rob_id   = '0;
        for (int i = 0; i < COM_WIDTH; i++) begin
            r_idx = head_q + ROB'(i);
            if (!reset && !stop && valid_q[r_idx] && done_q[r_idx]) begin
                ret_clr[r_idx]                = 1'b1;
                nret                          = nret + ONE_C;
                com_e_[i]                     = 1'b0;
                com_exp_[i]                   = exp_q[r_idx];
                com_pc[i*ADDR +: ADDR]        = pc_q[r_idx];
                com_rd[i*RD_W +: RD_W]        = rd_q[r_idx];
                com_exp_code[i*EXP_W +: EXP_W] = exp_code_q[r_idx];
                com_rob_id[i*ROB +: ROB]      = r_idx;
                if (!br_miss_q[r_idx] || !jump_miss_q[r_idx] || !exp_q[r_idx]) begin
                    flush = 1'b1;
                    stop  = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Rename lookups see a same-cycle writeback through the bypass
    for (genvar gi = 0; gi < 2*DEC_WIDTH; gi++) begin : g_ren
        logic [ROB-1:0] look_id;
        logic           byp;
        assign look_id = ren_id[gi*ROB +: ROB];
        always_comb begin
            byp = 1'b0;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (!wb_e_[p] && (wb_rob_id[p*ROB +: ROB] == look_id)) byp = 1'b1;
            end
        end
        assign ren_ready[gi] = !reset && (done_q[look_id] || byp);
    end

    // Next state; a flush discards everything else happening this cycle
    always_comb begin
        head_d  = head_q + nret[ROB-1:0];
        tail_d  = tail_q + nalloc[ROB-1:0];
        count_d = count_q + nalloc - nret;
        valid_d = valid_q;
        done_d  = done_q;
        for (int e = 0; e < ROB_DEPTH; e++) begin
            if (alloc_we[e]) begin
                valid_d[e] = 1'b1;
                done_d[e]  = dec_invalid[alloc_slot[e]];
            end else begin
                if (wb_we[e]) done_d[e] = 1'b1;
                if (ret_clr[e]) begin
                    valid_d[e] = 1'b0;
                    done_d[e]  = 1'b0;
                end
            end
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            done_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Payload needs no reset: it is only observed while valid and done are set
    always_ff @(posedge clk) begin
        for (int e = 0; e < ROB_DEPTH; e++) begin
            if (alloc_we[e]) begin
                pc_q[e]        <= dec_pc[alloc_slot[e]*ADDR +: ADDR];
                rd_q[e]        <= dec_rd[alloc_slot[e]*RD_W +: RD_W];
                br_miss_q[e]   <= 1'b1;
                jump_miss_q[e] <= 1'b1;
                exp_q[e]       <= !dec_invalid[alloc_slot[e]];
                exp_code_q[e]  <= dec_invalid[alloc_slot[e]] ? ILL_C : '0;
            end else if (wb_we[e]) begin
                br_miss_q[e]   <= wb_pred_miss_[wb_port[e]];
                jump_miss_q[e] <= wb_jump_miss_[wb_port[e]];
                exp_q[e]       <= wb_exp_[wb_port[e]];
                exp_code_q[e]  <= wb_exp_code[wb_port[e]*EXP_W +: EXP_W];
            end
        end
    end

endmodule

// File: tb/tb_rob_status_mw.sv
module tb_rob_status_mw;
    localparam int ADDR = 32, DEPTH = 8, DECW = 2, WBP = 2, COMW = 2;
    localparam int RDW = 5, EXPW = 4, ROBW = 3, ILL = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [DECW-1:0]       dec_e_;
    logic [DECW*ADDR-1:0]  dec_pc;
    logic [DECW*RDW-1:0]   dec_rd;
    logic [DECW-1:0]       dec_invalid;
    logic [ROBW-1:0]       dec_rob_id;
    logic [2*DECW*ROBW-1:0] ren_id;
    logic [2*DECW-1:0]     ren_ready;
    logic [WBP-1:0]        wb_e_, wb_exp_, wb_pred_miss_, wb_jump_miss_;
    logic [WBP*ROBW-1:0]   wb_rob_id;
    logic [WBP*EXPW-1:0]   wb_exp_code;
    logic [COMW-1:0]       com_e_, com_exp_;
    logic [COMW*ADDR-1:0]  com_pc;
    logic [COMW*RDW-1:0]   com_rd;
    logic [COMW*EXPW-1:0]  com_exp_code;
    logic [COMW*ROBW-1:0]  com_rob_id;
    logic                  flush_, rob_busy;

    rob_status_mw #(
        .ADDR(ADDR), .ROB_DEPTH(DEPTH), .DEC_WIDTH(DECW), .WB_PORTS(WBP),
        .COM_WIDTH(COMW), .RD_W(RDW), .EXP_W(EXPW), .ILLEGAL_CODE(ILL)
    ) dut (
        .clk(clk), .reset(reset),
        .dec_e_(dec_e_), .dec_pc(dec_pc), .dec_rd(dec_rd), .dec_invalid(dec_invalid),
        .dec_rob_id(dec_rob_id), .ren_id(ren_id), .ren_ready(ren_ready),
        .wb_e_(wb_e_), .wb_rob_id(wb_rob_id), .wb_exp_(wb_exp_),
        .wb_pred_miss_(wb_pred_miss_), .wb_jump_miss_(wb_jump_miss_), .wb_exp_code(wb_exp_code),
        .com_e_(com_e_), .com_pc(com_pc), .com_rd(com_rd), .com_exp_code(com_exp_code),
        .com_rob_id(com_rob_id), .com_exp_(com_exp_), .flush_(flush_), .rob_busy(rob_busy)
    );

    always #5 clk = ~clk;

    // Reference model: the ROB as an ordered list of in-flight instructions
    typedef struct {
        logic [ROBW-1:0] id;
        logic [ADDR-1:0] pc;
        logic [RDW-1:0]  rd;
        bit              done;
        bit              br_n, jm_n, ex_n;
        logic [EXPW-1:0] code;
    } ent_t;

    ent_t            q[$];
    logic [ROBW-1:0] m_tail;
    int              vectors = 0;
    int              miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dec_e_ = '1; dec_pc = '0; dec_rd = '0; dec_invalid = '0; ren_id = '0;
        wb_e_ = '1; wb_rob_id = '0; wb_exp_ = '1; wb_pred_miss_ = '1;
        wb_jump_miss_ = '1; wb_exp_code = '0;
    endtask

    task automatic set_alloc(input int n, input logic [ADDR-1:0] pc0, input logic inv0);
        for (int k = 0; k < DECW; k++) begin
            dec_e_[k] = !(k < n);
            dec_pc[k*ADDR +: ADDR] = pc0 + ADDR'(4*k);
            dec_rd[k*RDW +: RDW] = RDW'(k + 1);
        end
        dec_invalid[0] = inv0;
    endtask

    task automatic set_wb(input int p, input logic [ROBW-1:0] id, input logic pm_n, input logic ex_n);
        wb_e_[p] = 1'b0;
        wb_rob_id[p*ROBW +: ROBW] = id;
        wb_pred_miss_[p] = pm_n;
        wb_exp_[p] = ex_n;
        wb_exp_code[p*EXPW +: EXPW] = EXPW'(p + 5);
    endtask

    // Check outputs for the current inputs, advance the model over the next edge
    task automatic apply();
        bit busy, fl;
        int nret;
        logic [ROBW-1:0] rid;
        logic [COMW-1:0] e_com_e, e_com_exp;
        logic [COMW*ADDR-1:0] e_pc;
        logic [COMW*RDW-1:0] e_rd;
        logic [COMW*EXPW-1:0] e_code;
        logic [COMW*ROBW-1:0] e_id;
        logic [2*DECW-1:0] e_ren;
        ent_t t;
        #1;
        e_com_e = '1; e_com_exp = '1; e_pc = '0; e_rd = '0; e_code = '0; e_id = '0;
        e_ren = '0; fl = 0; nret = 0; busy = 0;
        if (!reset) begin
            busy = (DEPTH - q.size()) < DECW;
            for (int i = 0; i < COMW && i < q.size(); i++) begin
                if (!q[i].done) break;
                e_com_e[i] = 1'b0;
                e_com_exp[i] = q[i].ex_n;
                e_pc[i*ADDR +: ADDR] = q[i].pc;
                e_rd[i*RDW +: RDW] = q[i].rd;
                e_code[i*EXPW +: EXPW] = q[i].code;
                e_id[i*ROBW +: ROBW] = q[i].id;
                nret++;
                if (!(q[i].br_n && q[i].jm_n && q[i].ex_n)) begin
                    fl = 1;
                    break;
                end
            end
            for (int j = 0; j < 2*DECW; j++) begin
                rid = ren_id[j*ROBW +: ROBW];
                for (int p = 0; p < WBP; p++)
                    if (!wb_e_[p] && wb_rob_id[p*ROBW +: ROBW] == rid) e_ren[j] = 1'b1;
                foreach (q[k]) if (q[k].id == rid && q[k].done) e_ren[j] = 1'b1;
            end
        end
        chk("dec_rob_id", 64'(dec_rob_id), reset ? 64'd0 : 64'(m_tail));
        chk("rob_busy", 64'(rob_busy), 64'(busy));
        chk("com_e_", 64'(com_e_), 64'(e_com_e));
        chk("com_exp_", 64'(com_exp_), 64'(e_com_exp));
        chk("com_pc", 64'(com_pc), 64'(e_pc));
        chk("com_rd", 64'(com_rd), 64'(e_rd));
        chk("com_exp_code", 64'(com_exp_code), 64'(e_code));
        chk("com_rob_id", 64'(com_rob_id), 64'(e_id));
        chk("flush_", 64'(flush_), 64'(!fl));
        chk("ren_ready", 64'(ren_ready), 64'(e_ren));
        if (reset || fl) begin
            q.delete();
            m_tail = '0;
        end else begin
            for (int p = 0; p < WBP; p++) begin
                if (!wb_e_[p]) begin
                    foreach (q[k]) begin
                        if (q[k].id == wb_rob_id[p*ROBW +: ROBW]) begin
                            t = q[k];
                            t.done = 1;
                            t.br_n = wb_pred_miss_[p];
                            t.jm_n = wb_jump_miss_[p];
                            t.ex_n = wb_exp_[p];
                            t.code = wb_exp_code[p*EXPW +: EXPW];
                            q[k] = t;
                        end
                    end
                end
            end
            repeat (nret) void'(q.pop_front());
            if (!busy) begin
                for (int k = 0; k < DECW; k++) begin
                    if (!dec_e_[k]) begin
                        t.id = m_tail;
                        t.pc = dec_pc[k*ADDR +: ADDR];
                        t.rd = dec_rd[k*RDW +: RDW];
                        t.done = dec_invalid[k];
                        t.br_n = 1;
                        t.jm_n = 1;
                        t.ex_n = !dec_invalid[k];
                        t.code = dec_invalid[k] ? EXPW'(ILL) : '0;
                        q.push_back(t);
                        m_tail++;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        int n;
        idle();
        n = $urandom_range(0, DECW);
        for (int k = 0; k < DECW; k++) begin
            dec_e_[k] = !(k < n);
            dec_pc[k*ADDR +: ADDR] = $urandom;
            dec_rd[k*RDW +: RDW] = RDW'($urandom);
            dec_invalid[k] = ($urandom_range(0, 19) == 0);
        end
        for (int p = 0; p < WBP; p++) begin
            wb_e_[p] = ($urandom_range(0, 2) == 0);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                wb_rob_id[p*ROBW +: ROBW] = q[$urandom_range(0, q.size() - 1)].id;
            else
                wb_rob_id[p*ROBW +: ROBW] = ROBW'($urandom_range(0, DEPTH - 1));
            wb_exp_[p] = ($urandom_range(0, 24) != 0);
            wb_pred_miss_[p] = ($urandom_range(0, 24) != 0);
            wb_jump_miss_[p] = ($urandom_range(0, 24) != 0);
            wb_exp_code[p*EXPW +: EXPW] = EXPW'($urandom);
        end
        ren_id = (2*DECW*ROBW)'($urandom);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        m_tail = '0;
        @(negedge clk);
        apply();
        apply();
        reset = 1'b0;

        // Allocate two, ids 0 and 1
        idle(); set_alloc(2, 32'h100, 1'b0);
        #1 chk("tp_first_id", 64'(dec_rob_id), 64'd0);
        apply();
        idle();
        #1 chk("tp_next_id", 64'(dec_rob_id), 64'd2);
        chk("tp_no_early_retire", 64'(com_e_), 64'b11);
        apply();

        // Out-of-order completion, in-order retire
        idle(); set_wb(0, 3'd1, 1'b1, 1'b1); apply();
        idle(); set_wb(0, 3'd0, 1'b1, 1'b1);
        #1 chk("tp_wait_oldest", 64'(com_e_), 64'b11);
        apply();
        idle();
        #1 chk("tp_dual_retire", 64'(com_e_), 64'b00);
        chk("tp_dual_ids", 64'(com_rob_id), 64'b001_000);
        apply();

        // Fill to DEPTH-1, dropped allocation, retire one, wrap
        idle(); set_alloc(2, 32'h200, 1'b0); apply();
        idle(); set_alloc(2, 32'h210, 1'b0); apply();
        idle(); set_alloc(2, 32'h220, 1'b0); apply();
        idle(); set_alloc(1, 32'h230, 1'b0); apply();
        idle(); set_alloc(2, 32'h240, 1'b0);
        #1 chk("tp_busy_full", 64'(rob_busy), 64'd1);
        apply();
        idle(); set_wb(0, 3'd2, 1'b1, 1'b1); apply();
        idle();
        #1 chk("tp_retire_one", 64'(com_e_), 64'b10);
        chk("tp_busy_hold", 64'(rob_busy), 64'd1);
        apply();
        idle(); set_alloc(2, 32'h250, 1'b0);
        #1 chk("tp_busy_clear", 64'(rob_busy), 64'd0);
        chk("tp_wrap_id", 64'(dec_rob_id), 64'd1);
        apply();

        // Mispredict on the head entry flushes
        idle(); set_wb(0, 3'd3, 1'b0, 1'b1); set_wb(1, 3'd4, 1'b1, 1'b1); apply();
        idle();
        #1 chk("tp_flush_lane0", 64'(com_e_), 64'b10);
        chk("tp_flush_low", 64'(flush_), 64'd0);
        apply();
        idle();
        #1 chk("tp_post_flush_id", 64'(dec_rob_id), 64'd0);
        chk("tp_post_flush_idle", 64'(com_e_), 64'b11);
        apply();

        // Illegal instruction retires the next cycle with an exception
        idle(); set_alloc(1, 32'h300, 1'b1); apply();
        idle();
        #1 chk("tp_illegal_exp", 64'(com_exp_), 64'b10);
        chk("tp_illegal_flush", 64'(flush_), 64'd0);
        apply();

        // Both ports hit id 3; port 1 carries the exception
        idle(); set_alloc(2, 32'h400, 1'b0); apply();
        idle(); set_alloc(2, 32'h408, 1'b0); apply();
        idle(); set_wb(0, 3'd3, 1'b1, 1'b1); set_wb(1, 3'd3, 1'b1, 1'b0);
        ren_id[ROBW-1:0] = 3'd3;
        #1 chk("tp_ren_bypass", 64'(ren_ready[0]), 64'd1);
        apply();
        idle(); set_wb(0, 3'd0, 1'b1, 1'b1); set_wb(1, 3'd1, 1'b1, 1'b1); apply();
        idle(); set_wb(0, 3'd2, 1'b1, 1'b1); apply();
        idle();
        #1 chk("tp_port1_wins", 64'(com_exp_), 64'b01);
        chk("tp_port1_ids", 64'(com_rob_id), 64'b011_010);
        apply();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            apply();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
